// File: rtl/fp_arith_server.sv
// fp_arith: combinational single-precision adder/subtractor.
//   data_1_i, data_2_i : IEEE-754 binary32 operands A and B
//   op_sel_i           : 0 = A+B, 1 = A-B
//   data_o             : rounded result (round-to-nearest-even)
// Denormal inputs and underflowing results are flushed to zero and
// overflow saturates to infinity. NaN inputs are not special-cased.
//
// fp_arith_server: registered request stage feeding fp_arith, followed by
// an in-order result FIFO with a valid/ready response side.
//   clk, rst_n                          : clock, async active-low reset
//   req_valid/req_ready                 : request handshake
//   req_data_1/req_data_2/req_op_sel/req_tag : request payload
//   rsp_valid/rsp_ready                 : response handshake
//   rsp_data/rsp_tag/rsp_op_sel         : head-of-FIFO result payload
//   occupancy                           : FIFO entries + in-flight stage
// fp_arith is fixed at binary32, so DATA_WIDTH must stay 32.

module fp_arith (
    input  logic [31:0] data_1_i,
    input  logic [31:0] data_2_i,
    input  logic        op_sel_i,
    output logic [31:0] data_o
);
    logic        sign_b;
    logic        a_big;
    logic        sign_big;
    logic        eff_sub;
    logic [7:0]  exp_big;
    logic [7:0]  exp_small;
    logic [7:0]  exp_diff;
    logic [23:0] man_a;
    logic [23:0] man_b;
    logic [23:0] man_big;
    logic [23:0] man_small;
    logic [49:0] small_sh;
    logic [26:0] big_ext;
    logic [26:0] small_ext;
    logic [27:0] sum;
    logic [27:0] norm;
    logic [4:0]  lz;
    logic        found;
    logic        round_up;
    logic [24:0] man_rnd;
    logic [9:0]  exp_t;
    logic [9:0]  exp_r;

    always_comb begin
        sign_b  = data_2_i[31] ^ op_sel_i;
        eff_sub = data_1_i[31] ^ sign_b;
        man_a   = (|data_1_i[30:23]) ? {1'b1, data_1_i[22:0]} : '0;
        man_b   = (|data_2_i[30:23]) ? {1'b1, data_2_i[22:0]} : '0;
        a_big   = (data_1_i[30:0] >= data_2_i[30:0]);

        sign_big  = a_big ? data_1_i[31]     : sign_b;
        exp_big   = a_big ? data_1_i[30:23]  : data_2_i[30:23];
        exp_small = a_big ? data_2_i[30:23]  : data_1_i[30:23];
        man_big   = a_big ? man_a : man_b;
        man_small = a_big ? man_b : man_a;
        exp_diff  = exp_big - exp_small;

        // Align the smaller operand keeping guard, round and a sticky OR of
        // everything shifted further out.
        small_sh  = {man_small, 26'b0} >> exp_diff;
        small_ext = {small_sh[49:24], |small_sh[23:0]};
        big_ext   = {man_big, 3'b000};
        sum = eff_sub ? ({1'b0, big_ext} - {1'b0, small_ext})
                      : ({1'b0, big_ext} + {1'b0, small_ext});

        lz    = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 28; i++) begin
            if (!found && sum[27 - i]) begin
                lz    = i[4:0];
                found = 1'b1;
            end
        end
        norm = sum << lz;

        round_up = norm[3] & ((|norm[2:0]) | norm[4]);
        man_rnd  = {1'b0, norm[27:4]} + {24'b0, round_up};
        exp_t    = {2'b00, exp_big} + 10'd1 - {5'b0, lz};
        exp_r    = exp_t + {9'b0, man_rnd[24]};

        if (!found) begin
            data_o = '0;
        end else if (exp_r[9] || (exp_r == '0)) begin
            data_o = {sign_big, 31'b0};
        end else if (exp_r >= 10'd255) begin
            data_o = {sign_big, 8'hff, 23'b0};
        end else begin
            data_o = {sign_big, exp_r[7:0], man_rnd[24] ? man_rnd[23:1] : man_rnd[22:0]};
        end
    end
endmodule

module fp_arith_server #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [DATA_WIDTH-1:0]         req_data_1,
    input  logic [DATA_WIDTH-1:0]         req_data_2,
    input  logic                          req_op_sel,
    input  logic [TAG_WIDTH-1:0]          req_tag,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [TAG_WIDTH-1:0]          rsp_tag,
    output logic                          rsp_op_sel,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic                  stage_valid_q;
    logic [DATA_WIDTH-1:0] s1_a_q;
    logic [DATA_WIDTH-1:0] s1_b_q;
    logic                  s1_op_q;
    logic [TAG_WIDTH-1:0]  s1_tag_q;

    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]  fifo_tag_q  [FIFO_DEPTH];
    logic                  fifo_op_q   [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;

    logic [DATA_WIDTH-1:0] arith_res;
    logic                  req_fire;
    logic                  push;
    logic                  pop;
    logic [OCC_W-1:0]      occ;

    fp_arith u_fp_arith (
        .data_1_i (s1_a_q),
        .data_2_i (s1_b_q),
        .op_sel_i (s1_op_q),
        .data_o   (arith_res)
    );

    // Credit counts the in-flight stage, so a stage write can never find
    // the FIFO full; req_ready depends on registers only.
    assign occ        = count_q + OCC_W'(stage_valid_q);
    assign occupancy  = occ;
    assign req_ready  = (occ < OCC_W'(FIFO_DEPTH));
    assign req_fire   = req_valid & req_ready;
    assign push       = stage_valid_q;
    assign rsp_valid  = (count_q != '0);
    assign pop        = rsp_valid & rsp_ready;
    assign rsp_data   = fifo_data_q[rd_ptr_q];
    assign rsp_tag    = fifo_tag_q[rd_ptr_q];
    assign rsp_op_sel = fifo_op_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid_q <= 1'b0;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            s1_op_q       <= 1'b0;
            s1_tag_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_tag_q[i]  <= '0;
                fifo_op_q[i]   <= 1'b0;
            end
        end else begin
            stage_valid_q <= req_fire;
            if (req_fire) begin
                s1_a_q   <= req_data_1;
                s1_b_q   <= req_data_2;
                s1_op_q  <= req_op_sel;
                s1_tag_q <= req_tag;
            end
            if (push) begin
                fifo_data_q[wr_ptr_q] <= arith_res;
                fifo_tag_q[wr_ptr_q]  <= s1_tag_q;
                fifo_op_q[wr_ptr_q]   <= s1_op_q;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_fp_arith_server.sv
module tb_fp_arith_server;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_data_1;
    logic [31:0] req_data_2;
    logic        req_op_sel;
    logic [3:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        rsp_op_sel;
    logic [2:0]  occupancy;

    int n_checks;
    int n_errors;
    int nxt;
    int rcv;
    int stalls;
    int first_rx;
    int last_rx;

    logic [31:0] tb_a [16];
    logic [31:0] tb_b [16];
    logic [31:0] tb_e [16];
    logic        tb_op [16];

    fp_arith_server #(
        .DATA_WIDTH (32),
        .TAG_WIDTH  (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data_1 (req_data_1),
        .req_data_2 (req_data_2),
        .req_op_sel (req_op_sel),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_op_sel (rsp_op_sel),
        .occupancy  (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op, input logic [3:0] t);
        int w;
        req_data_1 = a;
        req_data_2 = b;
        req_op_sel = op;
        req_tag    = t;
        req_valid  = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin
            step();
            w++;
        end
        check_eq("send_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic expect_rsp(input logic [31:0] d, input logic [3:0] t, input logic o);
        int w;
        rsp_ready = 1'b1;
        w = 0;
        while (!rsp_valid && w < 20) begin
            step();
            w++;
        end
        check_eq("rsp_valid", rsp_valid, 1);
        check_eq("rsp_data", rsp_data, d);
        check_eq("rsp_tag", rsp_tag, t);
        check_eq("rsp_op", rsp_op_sel, o);
        step();
        rsp_ready = 1'b0;
    endtask

    // Drives table entries nxt..n-1 and checks responses against tb_e in
    // tag order; rsp_ready is left as set by the caller.
    task automatic pump(input int n, input int budget);
        int  cyc;
        logic acc;
        cyc = 0;
        while (rcv < n && cyc < budget) begin
            req_valid = (nxt < n);
            if (nxt < n) begin
                req_data_1 = tb_a[nxt];
                req_data_2 = tb_b[nxt];
                req_op_sel = tb_op[nxt];
                req_tag    = nxt[3:0];
            end
            acc = req_valid && req_ready;
            if (req_valid && !req_ready) stalls++;
            if (rsp_valid && rsp_ready) begin
                check_eq("pump_tag", rsp_tag, rcv[3:0]);
                check_eq("pump_data", rsp_data, tb_e[rcv]);
                check_eq("pump_op", rsp_op_sel, tb_op[rcv]);
                if (rcv == 0) first_rx = cyc;
                last_rx = cyc;
                rcv++;
            end
            step();
            if (acc) nxt++;
            cyc++;
        end
        req_valid = 1'b0;
        check_eq("pump_done", rcv, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_data_1 = '0;
        req_data_2 = '0;
        req_op_sel = 1'b0;
        req_tag    = '0;
        rsp_ready  = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_occ", occupancy, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_tag", rsp_tag, 0);
        check_eq("rst_rsp_op", rsp_op_sel, 0);
        #3 rst_n = 1'b1;
        step();

        // Single add, with two-cycle latency check
        send(32'h3f800000, 32'h40000000, 1'b0, 4'd3);
        check_eq("add_occ_s1", occupancy, 1);
        check_eq("add_early_valid", rsp_valid, 0);
        step();
        check_eq("add_valid", rsp_valid, 1);
        check_eq("add_data", rsp_data, 32'h40400000);
        check_eq("add_tag", rsp_tag, 3);
        check_eq("add_op", rsp_op_sel, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_eq("add_popped", rsp_valid, 0);
        check_eq("add_occ_end", occupancy, 0);

        // Single sub
        send(32'h40400000, 32'h3f800000, 1'b1, 4'd5);
        expect_rsp(32'h40000000, 4'd5, 1'b1);
        check_eq("sub_occ_end", occupancy, 0);

        // Fill with rsp_ready low: six requests, only four fit
        tb_a[0] = 32'h3f800000; tb_b[0] = 32'h40000000; tb_op[0] = 1'b0; tb_e[0] = 32'h40400000;
        tb_a[1] = 32'h40400000; tb_b[1] = 32'h3f800000; tb_op[1] = 1'b1; tb_e[1] = 32'h40000000;
        tb_a[2] = 32'h3fc00000; tb_b[2] = 32'h3fc00000; tb_op[2] = 1'b1; tb_e[2] = 32'h00000000;
        tb_a[3] = 32'h3c54fdf4; tb_b[3] = 32'h3ccccccd; tb_op[3] = 1'b0; tb_e[3] = 32'h3d1ba5e4;
        tb_a[4] = 32'h3c54fdf4; tb_b[4] = 32'h3ccccccd; tb_op[4] = 1'b1; tb_e[4] = 32'hbc449ba6;
        tb_a[5] = 32'h00000000; tb_b[5] = 32'h40a00000; tb_op[5] = 1'b0; tb_e[5] = 32'h40a00000;
        nxt = 0;
        rcv = 0;
        rsp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            req_valid  = (nxt < 6);
            req_data_1 = tb_a[nxt];
            req_data_2 = tb_b[nxt];
            req_op_sel = tb_op[nxt];
            req_tag    = nxt[3:0];
            check_eq("fill_ready", req_ready, (nxt < 4));
            check_eq("fill_occ", occupancy, nxt);
            if (req_valid && req_ready) begin
                step();
                nxt++;
            end else begin
                step();
            end
        end
        check_eq("fill_accepted", nxt, 4);
        check_eq("fill_full_ready", req_ready, 0);
        check_eq("fill_head_tag", rsp_tag, 0);
        rsp_ready = 1'b1;
        pump(6, 60);
        rsp_ready = 1'b0;
        check_eq("fill_occ_end", occupancy, 0);

        // Streaming throughput
        for (int i = 0; i < 16; i++) begin
            tb_a[i]  = 32'h3c54fdf4;
            tb_b[i]  = 32'h3ccccccd;
            tb_op[i] = i[0];
            tb_e[i]  = i[0] ? 32'hbc449ba6 : 32'h3d1ba5e4;
        end
        nxt = 0;
        rcv = 0;
        stalls = 0;
        first_rx = 0;
        last_rx = 0;
        rsp_ready = 1'b1;
        pump(16, 60);
        rsp_ready = 1'b0;
        check_eq("stream_stalls", stalls, 0);
        check_eq("stream_rx_span", last_rx - first_rx, 15);

        // Backpressure stability
        send(32'h3f800000, 32'h40000000, 1'b0, 4'd7);
        send(32'h40400000, 32'h3f800000, 1'b1, 4'd8);
        step();
        for (int c = 0; c < 5; c++) begin
            check_eq("bp_valid", rsp_valid, 1);
            check_eq("bp_data", rsp_data, 32'h40400000);
            check_eq("bp_tag", rsp_tag, 7);
            check_eq("bp_op", rsp_op_sel, 0);
            check_eq("bp_occ", occupancy, 2);
            step();
        end
        expect_rsp(32'h40400000, 4'd7, 1'b0);
        expect_rsp(32'h40000000, 4'd8, 1'b1);

        // Reset mid-stream with three results buffered
        send(32'h3f800000, 32'h3f800000, 1'b0, 4'd10);
        send(32'h3f800000, 32'h40000000, 1'b0, 4'd11);
        send(32'h40000000, 32'h3f800000, 1'b1, 4'd12);
        step();
        check_eq("mid_occ", occupancy, 3);
        #3 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", rsp_valid, 0);
        check_eq("mid_rst_occ", occupancy, 0);
        check_eq("mid_rst_ready", req_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check_eq("post_rst_valid", rsp_valid, 0);
            check_eq("post_rst_occ", occupancy, 0);
            step();
        end
        rsp_ready = 1'b0;
        send(32'h40400000, 32'h40400000, 1'b0, 4'd9);
        expect_rsp(32'h40c00000, 4'd9, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/fp_arith_server.md
Name: fp_arith_server

Overview:
- Sequential responder around the combinational fp_arith adder/subtractor. It is the consumer side of the operand/result stream that benches and the sci-acc datapath drive into fp_arith.
- Accepts tagged operand requests on a valid/ready interface and registers them into fp_arith. It captures each result into a small in-order result FIFO and returns results with their tags on a valid/ready response interface.
- Decouples upstream issue rate from downstream consumption and gives fp_arith a registered, glitch-free operand source.

Parameters:
- DATA_WIDTH, 32, IEEE-754 word width (same value as param.vh).
- TAG_WIDTH, 4, request tag width, returned unchanged with the result.
- FIFO_DEPTH, 4, result FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_data_1  in  DATA_WIDTH  operand A.
- req_data_2  in  DATA_WIDTH  operand B.
- req_op_sel  in  1  0 = A+B, 1 = A-B.
- req_tag  in  TAG_WIDTH  request id.
- rsp_valid  out  1  head result present.
- rsp_ready  in  1  consumer accepts head result.
- rsp_data  out  DATA_WIDTH  result word.
- rsp_tag  out  TAG_WIDTH  tag of the head result.
- rsp_op_sel  out  1  op_sel of the head result.
- occupancy  out  $clog2(FIFO_DEPTH)+1  FIFO entries plus in-flight stage.

Behaviour:
- Reset (async assert, sync release): stage_valid=0, FIFO empty, rd/wr pointers=0, rsp_valid=0, rsp_data/rsp_tag/rsp_op_sel=0, occupancy=0, req_ready=1.
- Stage S1 (operand register):
  - On a request handshake (req_valid & req_ready at the rising edge), S1 latches data_1, data_2, op_sel and tag, and sets stage_valid=1.
  - With no handshake, stage_valid clears to 0.
- fp_arith is instantiated once. Its inputs are fed only from the S1 registers, never directly from the ports.
- Stage S2 (FIFO write): at each edge with stage_valid=1, the FIFO writes {fp_arith data_o, tag, op_sel} at wr_ptr. Pointers wrap modulo FIFO_DEPTH.
- Latency: a request accepted at edge T has its result visible on rsp_* in the cycle after edge T+1 (2 cycles), provided the FIFO was empty. Otherwise the result waits behind older entries. Ordering is strictly FIFO by acceptance.
- Response handshake: rsp_valid = FIFO not empty. rsp_* show the head entry combinationally from storage. A pop occurs on rsp_valid & rsp_ready.
- rsp_data, rsp_tag and rsp_op_sel must hold stable while rsp_valid=1 and rsp_ready=0.
- Credit rule:
  - occupancy = fifo_count + stage_valid.
  - req_ready = (occupancy < FIFO_DEPTH).
  - req_ready is a function of registers only; no combinational path from rsp_ready or req_valid to req_ready.
  - This guarantees the S2 write never overflows.
- Simultaneous push and pop in one cycle: fifo_count is unchanged and both pointers advance. This is legal when full, because the pop frees the slot.
- Pop on an empty FIFO: ignored (rsp_valid=0).
- req_valid with req_ready=0: no state change. The requester must hold its inputs.
- Full steady state: with the FIFO full and rsp_ready=0, req_ready=0 indefinitely and no data is lost.
- Reset mid-operation: all in-flight and buffered results are discarded immediately. No response appears after rst_n deasserts until a new request is accepted.
- Arithmetic: the result equals fp_arith data_o for the registered operands. No rounding, NaN or denormal handling is added here.

Test Plan:
- Single add: 3f800000 + 40000000, op 0, tag 3 -> 2 cycles later rsp_valid=1, rsp_data=40400000, tag=3, op=0; occupancy returns to 0 after the pop.
- Single sub: 40400000 - 3f800000, op 1, tag 5 -> rsp_data=40000000, tag=5, rsp_op_sel=1.
- Back-to-back fill with rsp_ready=0:
  - Stimulus: 6 requests, tags 0..5, with rsp_ready held low.
  - Expected: exactly 4 accepted, req_ready=0 from the cycle occupancy reaches 4.
  - Then raise rsp_ready: tags 0..3 return in order, tags 4..5 are accepted afterwards and return in order.
- Streaming throughput: req_valid and rsp_ready both held high for 16 requests, alternating 3c54fdf4 ± 3ccccccd -> one accept and one response per cycle, every result matches an fp_arith reference model, and tags are in order.
- Backpressure stability: hold rsp_ready=0 for 5 cycles with the FIFO non-empty -> rsp_* unchanged each cycle, no pop.
- Reset mid-stream: assert rst_n=0 with 3 results buffered -> rsp_valid=0 and occupancy=0 immediately (asynchronously); after release no stale response; a new request returns correctly.
